// File: rtl/sap_pkg.sv
// Shared opcode encodings and microstep state enum for the SAP accumulator core.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_X1   = 3'd3,
        ST_X2   = 3'd4,
        ST_X3   = 3'd5
    } state_t;

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract for the accumulator; subtract is a + ~b + 1,
// so carry=1 on subtract means no borrow.
module sap_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W:0]   sum;
    logic [DATA_W-1:0] b_eff;

    always_comb begin
        b_eff  = sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
        result = sum[DATA_W-1:0];
        carry  = sum[DATA_W];
        zero   = (sum[DATA_W-1:0] == '0);
    end

endmodule

// File: rtl/sap_core.sv
// SAP accumulator CPU core: internal RAM, microstep FSM, handshaked load port
// and output channel, with run/step/stop control from HALT.
module sap_core
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step,
    input  logic              stop,
    input  logic              pc_clr,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              halted,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] a_reg,
    output logic              flag_c,
    output logic              flag_z,
    output state_t            core_state
);

    // Handshakes: a transfer happens on any rising clk edge where valid and
    // ready are both 1; the producer holds valid and data steady until then.

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W-1:0] ir;
    logic [DATA_W-1:0] b_reg;
    logic [ADDR_W-1:0] mar;
    logic [3:0]        opcode;
    logic [3:0]        fetch_op;
    logic [ADDR_W-1:0] operand;
    logic              stop_q;
    logic              run_q;
    logic              out_xfer;
    logic              is_arith;
    logic              sta_write;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    state_t state_q;
    state_t state_d;
    state_t done_state;

    assign mem_rd   = mem[mar];
    assign opcode   = ir[DATA_W-1 -: 4];
    assign fetch_op = mem_rd[DATA_W-1 -: 4];
    assign operand  = ir[ADDR_W-1:0];
    assign out_xfer = out_valid && out_ready;

    assign halted     = (state_q == ST_HALT);
    assign core_state = state_q;

    // A stop seen on the final microstep counts just like a latched one.
    assign done_state = (stop_q || stop || !run_q) ? ST_HALT : ST_F0;

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (a_reg),
        .b      (b_reg),
        .sub    (opcode == OP_SUB),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_HALT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        is_arith   = (opcode == OP_ADD) || (opcode == OP_SUB);
        sta_write  = 1'b0;
        case (state_q)
            ST_HALT: begin
                load_ready = 1'b1;
                if (step || start) state_d = ST_F0;
            end
            ST_F0: state_d = ST_F1;
            ST_F1: state_d = ST_X1;
            ST_X1: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = ST_X2;
                    OP_OUT:  if (out_xfer) state_d = done_state;
                    OP_HLT:  state_d = ST_HALT;
                    default: state_d = done_state;
                endcase
            end
            ST_X2: begin
                sta_write = (opcode == OP_STA);
                state_d   = is_arith ? ST_X3 : done_state;
            end
            ST_X3:   state_d = done_state;
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= '0;
            ir        <= '0;
            mar       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            flag_c    <= 1'b0;
            flag_z    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            stop_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            if (state_q == ST_HALT) begin
                if (step) run_q <= 1'b0;
                else if (start) run_q <= 1'b1;
                if (pc_clr) pc <= '0;
            end

            if (state_d == ST_HALT) stop_q <= 1'b0;
            else if (stop && state_q != ST_HALT) stop_q <= 1'b1;

            case (state_q)
                ST_F0: mar <= pc;
                ST_F1: begin
                    ir <= mem_rd;
                    pc <= pc + ADDR_W'(1);
                    // Raise out_valid on entry to X1 so data is stable the whole stall.
                    if (fetch_op == OP_OUT) begin
                        out_valid <= 1'b1;
                        out_data  <= a_reg;
                    end
                end
                ST_X1: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: mar <= operand;
                        OP_LDI:  a_reg <= DATA_W'(operand);
                        OP_JMP:  pc <= operand;
                        OP_JC:   if (flag_c) pc <= operand;
                        OP_JZ:   if (flag_z) pc <= operand;
                        OP_OUT:  if (out_xfer) out_valid <= 1'b0;
                        default: ;
                    endcase
                end
                ST_X2: begin
                    if (opcode == OP_LDA) a_reg <= mem_rd;
                    else if (is_arith) b_reg <= mem_rd;
                end
                ST_X3: begin
                    a_reg  <= alu_result;
                    flag_c <= alu_carry;
                    flag_z <= alu_zero;
                end
                default: ;
            endcase
        end
    end

    // Loader writes only in HALT and STA only while running, so they never collide.
    always_ff @(posedge clk) begin
        if (load_valid && load_ready) mem[load_addr] <= load_data;
        else if (sta_write) mem[mar] <= a_reg;
    end

endmodule

// File: tb/tb_sap_core.sv
// Self-checking bench for sap_core: loads small programs, runs them and
// scores OUT transfers against an expected queue.
module tb_sap_core;
    import sap_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          step = 1'b0;
    logic          stop = 1'b0;
    logic          pc_clr = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          halted;
    logic [AW-1:0] pc;
    logic [DW-1:0] a_reg;
    logic          flag_c;
    logic          flag_z;
    state_t        core_state;

    int n_checks = 0;
    int n_fail = 0;
    int cyc;
    logic [DW-1:0] exp_q[$];

    sap_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .step       (step),
        .stop       (stop),
        .pc_clr     (pc_clr),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .halted     (halted),
        .pc         (pc),
        .a_reg      (a_reg),
        .flag_c     (flag_c),
        .flag_z     (flag_z),
        .core_state (core_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int addr, input int data, input logic clr);
        load_valid = 1'b1;
        load_addr  = addr[AW-1:0];
        load_data  = data[DW-1:0];
        pc_clr     = clr;
        tick();
        load_valid = 1'b0;
        pc_clr     = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_halted(input int budget, output int cycles);
        cycles = 0;
        while (1) begin
            @(negedge clk);
            if (halted) break;
            cycles++;
            if (cycles > budget) begin
                check("halt_timeout", 32'(cycles), 32'(budget));
                break;
            end
        end
    endtask

    // Scoreboard: every accepted OUT transfer pops one expected value.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("out_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_halted", 32'(halted), 1);
        check("rst_pc", 32'(pc), 0);
        check("rst_a", 32'(a_reg), 0);
        check("rst_flags", 32'({flag_c, flag_z}), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_load_ready", 32'(load_ready), 1);

        // LDA 14; ADD 15; OUT; HLT
        tick();
        load_word(0, 'h1E, 1'b1);
        load_word(1, 'h2F, 1'b0);
        load_word(2, 'hE0, 1'b0);
        load_word(3, 'hF0, 1'b0);
        load_word(14, 28, 1'b0);
        load_word(15, 14, 1'b0);
        exp_q.push_back(8'd42);
        pulse_start();
        @(negedge clk);
        check("t1_halt_drop", 32'(halted), 0);
        wait_halted(40, cyc);
        check("t1_cycles", 32'(cyc + 1), 15);
        check("t1_a", 32'(a_reg), 42);
        check("t1_flags", 32'({flag_c, flag_z}), 0);
        check("t1_pc", 32'(pc), 4);
        check("t1_outs", 32'(exp_q.size()), 0);

        // LDI 5; SUB 13; JZ 10 in single steps; first step collides with start
        tick();
        load_word(0, 'h55, 1'b1);
        load_word(1, 'h3D, 1'b0);
        load_word(2, 'h8A, 1'b0);
        load_word(13, 5, 1'b0);
        step = 1'b1;
        start = 1'b1;
        tick();
        step = 1'b0;
        start = 1'b0;
        wait_halted(20, cyc);
        check("t2_ldi_cycles", 32'(cyc), 3);
        check("t2_ldi_a", 32'(a_reg), 5);
        check("t2_ldi_pc", 32'(pc), 1);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_halted(20, cyc);
        check("t2_sub_cycles", 32'(cyc), 5);
        check("t2_sub_a", 32'(a_reg), 0);
        check("t2_sub_cz", 32'({flag_c, flag_z}), 3);
        check("t2_sub_pc", 32'(pc), 2);
        tick();
        step = 1'b1;
        tick();
        step = 1'b0;
        wait_halted(20, cyc);
        check("t2_jz_cycles", 32'(cyc), 3);
        check("t2_jz_pc", 32'(pc), 10);

        // 200+100 overflows; JC 5 skips the HLT at 3 and reaches OUT at 5
        tick();
        load_word(0, 'h1C, 1'b1);
        load_word(1, 'h2D, 1'b0);
        load_word(2, 'h75, 1'b0);
        load_word(3, 'hF0, 1'b0);
        load_word(5, 'hE0, 1'b0);
        load_word(6, 'hF0, 1'b0);
        load_word(12, 200, 1'b0);
        load_word(13, 100, 1'b0);
        exp_q.push_back(8'd44);
        pulse_start();
        wait_halted(60, cyc);
        check("t3_a", 32'(a_reg), 44);
        check("t3_cz", 32'({flag_c, flag_z}), 2);
        check("t3_pc", 32'(pc), 7);
        check("t3_outs", 32'(exp_q.size()), 0);

        // OUT stall with backpressure, stop arriving mid-stall
        tick();
        load_word(0, 'h59, 1'b1);
        load_word(1, 'hE0, 1'b0);
        load_word(2, 'h53, 1'b0);
        load_word(3, 'hF0, 1'b0);
        out_ready = 1'b0;
        exp_q.push_back(8'd9);
        pulse_start();
        cyc = 0;
        while (1) begin
            @(negedge clk);
            if (out_valid) break;
            cyc++;
            if (cyc > 20) begin
                check("t4_valid_timeout", 32'(cyc), 20);
                break;
            end
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_valid", 32'(out_valid), 1);
            check("t4_stall_data", 32'(out_data), 9);
            check("t4_stall_pc", 32'(pc), 2);
        end
        tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t4_valid_drop", 32'(out_valid), 0);
        check("t4_stop_halted", 32'(halted), 1);
        check("t4_a", 32'(a_reg), 9);
        check("t4_pc", 32'(pc), 2);
        check("t4_outs", 32'(exp_q.size()), 0);

        // Loads refused while running; stop during ADD completes the ADD first
        tick();
        load_word(0, 'h1C, 1'b1);
        load_word(1, 'h2D, 1'b0);
        load_word(2, 'h2D, 1'b0);
        load_word(3, 'hF0, 1'b0);
        load_word(12, 1, 1'b0);
        load_word(13, 2, 1'b0);
        load_word(15, 'h33, 1'b0);
        pulse_start();
        load_valid = 1'b1;
        load_addr  = 4'd15;
        load_data  = 8'h77;
        @(negedge clk);
        check("t5_load_ready", 32'(load_ready), 0);
        repeat (5) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        load_valid = 1'b0;
        wait_halted(20, cyc);
        check("t5_a", 32'(a_reg), 3);
        check("t5_pc", 32'(pc), 2);
        check("t5_mem15", 32'(dut.mem[15]), 'h33);

        // Reset while ADD is in X2
        tick();
        load_word(0, 'h1C, 1'b1);
        load_word(1, 'h2D, 1'b0);
        load_word(2, 'hF0, 1'b0);
        pulse_start();
        repeat (7) tick();
        rst = 1'b1;
        @(negedge clk);
        check("t6_state_x2", 32'(core_state), 32'(ST_X2));
        check("t6_a_before", 32'(a_reg), 1);
        @(negedge clk);
        check("t6_pc", 32'(pc), 0);
        check("t6_a", 32'(a_reg), 0);
        check("t6_flags", 32'({flag_c, flag_z}), 0);
        check("t6_halted", 32'(halted), 1);
        check("t6_out_valid", 32'(out_valid), 0);
        tick();
        rst = 1'b0;
        check("t6_mem12", 32'(dut.mem[12]), 1);
        check("t6_mem13", 32'(dut.mem[13]), 2);
        check("t6_mem14", 32'(dut.mem[14]), 28);
        check("t6_mem15", 32'(dut.mem[15]), 'h33);

        check("final_queue", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sap_core.md
# sap_core

Parametrised accumulator CPU core for the 8-bit computer. It holds its own RAM, program counter, instruction register, A/B registers, ALU and flags behind a microstep state machine, and it is free of board I/O. The core adds a handshaked program-load port, a handshaked output channel with backpressure, and run/step/stop control. The board top level wraps it, connecting the UART loader to the load port and the display driver to the output channel.

## Interface
- DATA_W, 8, word width of RAM, A, B and output data; must satisfy DATA_W ≥ ADDR_W+4
- ADDR_W, 4, RAM address width; depth is 2**ADDR_W
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse: begin continuous run from HALT
- step  in  1  one-cycle pulse: execute exactly one instruction from HALT
- stop  in  1  one-cycle pulse: halt at the next instruction boundary
- pc_clr  in  1  in HALT: PC←0
- load_valid / load_ready  in/out  1  RAM write handshake; ready=1 only in HALT
- load_addr  in  ADDR_W  RAM write address
- load_data  in  DATA_W  RAM write data
- out_valid / out_ready  out/in  1  output channel handshake
- out_data  out  DATA_W  value of A captured by OUT
- halted  out  1  core is in HALT
- pc  out  ADDR_W  program counter
- a_reg  out  DATA_W  accumulator
- flag_c, flag_z  out  1  carry and zero flags

## Operation
- Instruction format: opcode = word[DATA_W-1 -: 4]; operand = word[ADDR_W-1:0].
- Opcodes: NOP=0, LDA=1, ADD=2, SUB=3, STA=4, LDI=5, JMP=6, JC=7, JZ=8, OUT=E, HLT=F. Undefined opcodes execute as NOP.
- States: HALT, F0, F1, X1, X2, X3.
- F0: MAR←PC.
- F1: IR←mem[MAR]; PC←PC+1, wrapping mod 2**ADDR_W.
- LDA: X1 MAR←op; X2 A←mem.
- ADD/SUB: X1 MAR←op; X2 B←mem; X3 A←A±B and flags update.
- STA: X1 MAR←op; X2 mem←A.
- LDI: X1 A←zero-extended operand.
- JMP: X1 PC←op.
- JC/JZ: X1 PC←op only if the flag is set; otherwise no effect.
- OUT: X1 asserts out_valid with out_data=A and holds until out_ready.
- HLT: X1 → HALT.
- NOP: X1 only.
- Arithmetic is DATA_W bits. SUB computes A+~B+1, so C=1 means no borrow. Z=(result==0). Only ADD and SUB write the flags.
- HALT exits:
  - step → F0; the core returns to HALT after that instruction.
  - start → F0; the core runs continuously.
  - If step and start arrive together, step wins.
- While running, stop is latched. At the end of the current instruction the core goes to HALT and never aborts mid-instruction. stop has no effect in HALT.
- Load port: a RAM write occurs on each cycle with load_valid & load_ready. pc_clr and a load may happen in the same cycle.
- Reset clears PC, IR, MAR, A, B, flags, out_valid and the stop latch, and sets state=HALT (halted=1). RAM contents are not reset.

## Timing
- Cycles per instruction: LDA 4, ADD/SUB 5, STA 4, LDI/JMP/JC/JZ/NOP/HLT 3, OUT 3 plus stall cycles.
- A start pulse in cycle t puts the core in F0 at t+1; halted drops at t+1.
- Register writes are visible on the outputs the cycle after the state that performs them.
- out_data stays stable while out_valid=1. Transfer happens when valid & ready; out_valid drops the next cycle and F0 follows.
- A stop arriving during an OUT stall takes effect after the transfer.
- Reset in any state, including an OUT stall, takes effect next cycle.

## Structure
- Package sap_pkg holds the opcode localparams and the state enum.
- Sub-module sap_alu: combinational add/sub, parametrised by DATA_W, with carry and zero outputs.
- RAM is an internal array with a combinational read and a synchronous write.

## Test plan
- DATA_W=8, ADDR_W=4. Load program LDA 14; ADD 15; OUT; HLT with mem[14]=28 and mem[15]=14, then pulse start → single out_valid with data 42, C=0, Z=0, halted reasserts 15 cycles after F0 entry.
- Program LDI 5; SUB 13 (mem[13]=5); JZ 10 → A=0, Z=1, C=1, pc=10.
- ADD of 200+100 → A=44, C=1, Z=0; a following JC is taken.
- OUT with out_ready held low for 5 cycles → out_valid stays high, out_data stays constant, pc unchanged; transfer occurs on the cycle ready rises.
- Step pulse in HALT → exactly one instruction executes. While running, load_ready=0 and no RAM change. A stop during ADD → A updated, then halted.
- rst during ADD X2 → next cycle pc=0, a_reg=0, flags 0, halted=1, out_valid=0; RAM readback unchanged.
